// File: rtl/runtime_cfg_unit_pkg.sv
// Shared types and address map for the runtime configuration unit.
// Consumers size their config taps from CFG_N_REGS.
package runtime_cfg_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        APPLY,
        RELEASE
    } cfg_state_t;

    localparam int CFG_N_REGS = 8;

    localparam logic [7:0] CFG_ADDR_VERSION     = 8'h00;
    localparam logic [7:0] CFG_ADDR_STATUS      = 8'h01;
    localparam logic [7:0] CFG_ADDR_CTRL        = 8'h02;
    localparam logic [7:0] CFG_ADDR_SHADOW_BASE = 8'h10;
    localparam logic [7:0] CFG_ADDR_ACTIVE_BASE = 8'h20;

    localparam int CFG_CTRL_COMMIT  = 0;
    localparam int CFG_CTRL_CLR_ERR = 1;

endpackage

// File: rtl/runtime_cfg_unit_if.sv
// Host register bus of the runtime configuration unit.
// Writes use valid/ready; reads are always accepted with a 1-cycle response.
interface runtime_cfg_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              wvalid;
    logic              wready;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;

    modport master (
        output wvalid, waddr, wdata, rvalid, raddr,
        input  wready, rdata, rdata_valid
    );

    modport slave (
        input  wvalid, waddr, wdata, rvalid, raddr,
        output wready, rdata, rdata_valid
    );
endinterface

// File: rtl/runtime_cfg_unit_quiesce_fsm.sv
// Commit sequencer: drains all tiles, strobes the copy, then releases them.
// Owns the drain timeout and the sticky timeout flag.
module runtime_cfg_unit_quiesce_fsm
    import runtime_cfg_unit_pkg::*;
#(
    parameter int N_TILES        = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               clr_err,
    input  logic [N_TILES-1:0] quiesce_ack,
    output logic [N_TILES-1:0] quiesce_req,
    output logic               apply,
    output logic               idle,
    output logic               busy,
    output logic               err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    cfg_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign idle  = (state == IDLE);
    assign busy  = (state != IDLE);
    assign apply = (state == APPLY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            quiesce_req <= '0;
            err         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // clear is ordered before start so CTRL=3 retries cleanly
                    if (clr_err) err <= 1'b0;
                    if (start) begin
                        state       <= DRAIN;
                        cnt         <= '0;
                        quiesce_req <= '1;
                    end
                end
                DRAIN: begin
                    if (&quiesce_ack) begin
                        state <= APPLY;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RELEASE;
                        quiesce_req <= '0;
                        err         <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                APPLY: begin
                    state       <= RELEASE;
                    quiesce_req <= '0;
                end
                RELEASE: begin
                    if (quiesce_ack == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/runtime_cfg_unit.sv
// Host-writable shadow/active tuning registers broadcast to all tiles.
// Active words change only on the single APPLY cycle of a quiesced commit.
module runtime_cfg_unit
    import runtime_cfg_unit_pkg::*;
#(
    parameter int N_TILES        = 1,
    parameter int N_CFG_REGS     = CFG_N_REGS,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int GEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CFG_VERSION    = 10,
    parameter logic [N_CFG_REGS*DATA_W-1:0] RESET_VALUES = '0
) (
    input  logic                         clk,
    input  logic                         rstn,
    runtime_cfg_unit_if.slave            cfg,
    output logic [N_TILES-1:0]           quiesce_req,
    input  logic [N_TILES-1:0]           quiesce_ack,
    output logic [N_CFG_REGS*DATA_W-1:0] cfg_active,
    output logic [GEN_W-1:0]             cfg_gen,
    output logic                         cfg_busy,
    output logic                         cfg_err
);
    localparam int W = N_CFG_REGS * DATA_W;

    logic [W-1:0]      shadow;
    logic [W-1:0]      active;
    logic              idle;
    logic              apply;
    logic              wr_fire;
    logic              wr_ctrl;
    logic              w_sh;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] r_sh_off;
    logic [ADDR_W-1:0] r_act_off;
    logic [DATA_W-1:0] sh_word;
    logic [DATA_W-1:0] act_word;
    logic [DATA_W-1:0] rmux;

    assign cfg.wready = idle;
    assign wr_fire    = cfg.wvalid & idle;
    assign wr_ctrl    = wr_fire && (cfg.waddr == ADDR_W'(CFG_ADDR_CTRL));
    // addresses below the base wrap high and fall out of the window
    assign w_off      = cfg.waddr - ADDR_W'(CFG_ADDR_SHADOW_BASE);
    assign w_sh       = wr_fire && (w_off < ADDR_W'(N_CFG_REGS));
    assign cfg_active = active;

    runtime_cfg_unit_quiesce_fsm #(
        .N_TILES        (N_TILES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk         (clk),
        .rstn        (rstn),
        .start       (wr_ctrl & cfg.wdata[CFG_CTRL_COMMIT]),
        .clr_err     (wr_ctrl & cfg.wdata[CFG_CTRL_CLR_ERR]),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .apply       (apply),
        .idle        (idle),
        .busy        (cfg_busy),
        .err         (cfg_err)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow  <= RESET_VALUES;
            active  <= RESET_VALUES;
            cfg_gen <= '0;
        end else begin
            if (w_sh) begin
                for (int i = 0; i < N_CFG_REGS; i++) begin
                    if (w_off == ADDR_W'(i))
                        shadow[i*DATA_W +: DATA_W] <= cfg.wdata;
                end
            end
            if (apply) begin
                active  <= shadow;
                cfg_gen <= cfg_gen + 1'b1;
            end
        end
    end

    always_comb begin
        r_sh_off  = cfg.raddr - ADDR_W'(CFG_ADDR_SHADOW_BASE);
        r_act_off = cfg.raddr - ADDR_W'(CFG_ADDR_ACTIVE_BASE);
        sh_word   = '0;
        act_word  = '0;
        for (int i = 0; i < N_CFG_REGS; i++) begin
            if (r_sh_off == ADDR_W'(i))
                sh_word = shadow[i*DATA_W +: DATA_W];
            if (r_act_off == ADDR_W'(i))
                act_word = active[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        rmux = '0;
        unique case (1'b1)
            cfg.raddr == ADDR_W'(CFG_ADDR_VERSION):
                rmux = DATA_W'(CFG_VERSION);
            cfg.raddr == ADDR_W'(CFG_ADDR_STATUS):
                rmux = DATA_W'({cfg_err, cfg_busy, cfg_gen});
            r_sh_off < ADDR_W'(N_CFG_REGS):
                rmux = sh_word;
            r_act_off < ADDR_W'(N_CFG_REGS):
                rmux = act_word;
            default:
                rmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg.rdata       <= '0;
            cfg.rdata_valid <= 1'b0;
        end else begin
            cfg.rdata_valid <= cfg.rvalid;
            if (cfg.rvalid) cfg.rdata <= rmux;
        end
    end

endmodule

// File: tb/tb_runtime_cfg_unit.sv
// Self-checking bench: per-cycle compare against a register-level model
// plus directed literal checks of reset, commit, timeout, stall and wrap.
module tb_runtime_cfg_unit;
    import runtime_cfg_unit_pkg::*;

    localparam int NT = 2;
    localparam int NR = 8;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int GW = 8;
    localparam int TO = 16;
    localparam logic [NR*DW-1:0] RV = {
        32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
        32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic [NT-1:0] qreq;
    logic [NT-1:0] qack = '0;
    logic [NR*DW-1:0] act;
    logic [GW-1:0] gen;
    logic          busy;
    logic          err;

    runtime_cfg_unit_if #(.ADDR_W(AW), .DATA_W(DW)) cfg ();

    runtime_cfg_unit #(
        .N_TILES(NT), .N_CFG_REGS(NR), .DATA_W(DW), .ADDR_W(AW),
        .GEN_W(GW), .TIMEOUT_CYCLES(TO), .CFG_VERSION(10),
        .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg(cfg),
        .quiesce_req(qreq), .quiesce_ack(qack),
        .cfg_active(act), .cfg_gen(gen),
        .cfg_busy(busy), .cfg_err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string n, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    // tiles: ack mirrors req after ack_dly negedges, stuck bits never ack
    int            ack_dly = 0;
    logic [NT-1:0] stuck = '0;
    logic [NT-1:0] hist[16];

    initial begin
        for (int i = 0; i < 16; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = qreq;
            #1 qack = hist[ack_dly] & ~stuck;
        end
    end

    // behavioural model of the register file and commit protocol
    logic [31:0] m_sh[NR];
    logic [31:0] m_act[NR];
    logic [31:0] m_rd;
    bit          m_rv;
    bit          m_err;
    bit          m_req;
    int          m_phase;
    int          m_cnt;
    int          m_gen;

    function automatic logic [31:0] mread(int a);
        if (a == 0) return 32'd10;
        if (a == 1) return (32'(m_err) << 9) | (32'(m_phase != 0) << 8) | 32'(m_gen);
        if (a >= 16 && a < 16 + NR) return m_sh[a-16];
        if (a >= 32 && a < 32 + NR) return m_act[a-32];
        return 32'd0;
    endfunction

    function automatic logic [NR*DW-1:0] mpack();
        logic [NR*DW-1:0] p;
        for (int i = 0; i < NR; i++) p[i*DW +: DW] = m_act[i];
        return p;
    endfunction

    task automatic model_step();
        int a;
        if (!rstn) begin
            for (int i = 0; i < NR; i++) begin
                m_sh[i]  = RV[i*DW +: DW];
                m_act[i] = RV[i*DW +: DW];
            end
            m_rd = 0; m_rv = 0; m_err = 0; m_req = 0;
            m_phase = 0; m_cnt = 0; m_gen = 0;
            return;
        end
        if (cfg.rvalid) m_rd = mread(int'(cfg.raddr));
        m_rv = cfg.rvalid;
        a = int'(cfg.waddr);
        case (m_phase)
            0: if (cfg.wvalid) begin
                if (a >= 16 && a < 16 + NR) m_sh[a-16] = cfg.wdata;
                if (a == 2) begin
                    if (cfg.wdata[1]) m_err = 0;
                    if (cfg.wdata[0]) begin
                        m_phase = 1; m_cnt = 0; m_req = 1;
                    end
                end
            end
            1: if (&qack) m_phase = 2;
               else if (m_cnt == TO - 1) begin
                   m_phase = 3; m_req = 0; m_err = 1;
               end else m_cnt++;
            2: begin
                for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
                m_gen = (m_gen + 1) % 256;
                m_phase = 3; m_req = 0;
            end
            default: if (qack == '0) m_phase = 0;
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("wready", cfg.wready, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("err", err, m_err);
            chk("gen", gen, m_gen);
            chk("qreq", qreq, m_req ? {NT{1'b1}} : '0);
            chk("active", act, mpack());
            chk("rvalid", cfg.rdata_valid, m_rv);
            if (m_rv) chk("rdata", cfg.rdata, m_rd);
        end
    end

    logic [31:0] rd_q;
    int          last_stalls;

    task automatic xact(input bit w, input logic [7:0] a, input logic [31:0] d,
                        input bit r, input logic [7:0] ra);
        bit acc;
        @(negedge clk); #1;
        cfg.wvalid = w; cfg.waddr = a; cfg.wdata = d;
        cfg.rvalid = r; cfg.raddr = ra;
        acc = cfg.wready;
        last_stalls = 0;
        @(negedge clk);
        rd_q = cfg.rdata;
        #1 cfg.rvalid = 1'b0;
        while (w && !acc && last_stalls < 400) begin
            acc = cfg.wready;
            last_stalls++;
            @(negedge clk); #1;
        end
        if (w && !acc) chk("write_accept", 0, 1);
        cfg.wvalid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        xact(1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string n);
        xact(1'b0, 8'h00, 32'h0, 1'b1, a);
        chk(n, rd_q, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk); #1; n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    logic [7:0] atab[12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11,
                             8'h15, 8'h17, 8'h18, 8'h20, 8'h27, 8'h28};

    initial begin
        int n;
        logic [GW-1:0] g0;
        cfg.wvalid = 0; cfg.waddr = 0; cfg.wdata = 0;
        cfg.rvalid = 0; cfg.raddr = 0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;

        chk("rst_gen", gen, 0);
        chk("rst_active", act, RV);
        rd(8'h00, 32'd10, "version");
        for (int i = 0; i < NR; i++)
            rd(8'h20 + 8'(i), 32'hC0DE0000 + 32'(i), "rst_active_rd");
        rd(8'h01, 32'h0, "rst_status");
        rd(8'h02, 32'h0, "ctrl_wo");
        rd(8'h30, 32'h0, "unmapped");

        wr(8'h10, 32'hDEADBEEF);
        rd(8'h10, 32'hDEADBEEF, "shadow0");
        rd(8'h20, 32'hC0DE0000, "active0_held");
        chk("active0_pin", act[31:0], 32'hC0DE0000);

        ack_dly = 5;
        wr(8'h02, 32'h1);
        chk("commit_busy", busy, 1);
        chk("commit_wready", cfg.wready, 0);
        chk("commit_no_copy", act[31:0], 32'hC0DE0000);
        wait_idle();
        chk("commit_active0", act[31:0], 32'hDEADBEEF);
        chk("commit_gen", gen, 1);

        stuck = 2'b10;
        wr(8'h11, 32'h12345678);
        wr(8'h02, 32'h1);
        n = 0;
        while (qreq != '0 && n < 100) begin
            n++; @(negedge clk); #1;
        end
        chk("drain_len", n, TO);
        wait_idle();
        chk("to_err", err, 1);
        chk("to_gen", gen, 1);
        chk("to_active1", act[63:32], 32'hC0DE0001);
        rd(8'h01, 32'h201, "to_status");
        stuck = '0;
        wr(8'h02, 32'h2);
        chk("clr_err", err, 0);

        ack_dly = 6;
        wr(8'h02, 32'h1);
        wr(8'h12, 32'hA5A5A5A5);
        chk("stalled", last_stalls != 0, 1);
        rd(8'h12, 32'hA5A5A5A5, "shadow2");
        chk("stall_gen", gen, 2);
        chk("stall_active1", act[63:32], 32'h12345678);

        xact(1'b1, 8'h13, 32'h0000FACE, 1'b1, 8'h13);
        chk("rw_old", rd_q, 32'hC0DE0003);
        rd(8'h13, 32'h0000FACE, "rw_new");

        stuck = 2'b01;
        wr(8'h02, 32'h1);
        wait_idle();
        chk("err_again", err, 1);
        stuck = '0; ack_dly = 2;
        wr(8'h02, 32'h3);
        chk("ctrl3_clr", err, 0);
        chk("ctrl3_busy", busy, 1);
        wait_idle();
        chk("ctrl3_gen", gen, 3);
        chk("ctrl3_active3", act[127:96], 32'h0000FACE);

        ack_dly = 6;
        wr(8'h02, 32'h1);
        @(negedge clk); #1;
        chk("mid_drain_req", qreq, 2'b11);
        rstn = 1'b0; #1;
        chk("rst_drain_req", qreq, 0);
        chk("rst_drain_gen", gen, 0);
        chk("rst_drain_act", act, RV);
        @(negedge clk); #1 rstn = 1'b1;

        ack_dly = 0;
        wr(8'h10, 32'h11111111);
        wr(8'h02, 32'h1);
        wait_idle();
        chk("pre_apply_gen", gen, 1);
        wr(8'h10, 32'h22222222);
        wr(8'h02, 32'h1);
        @(negedge clk); #1;
        chk("in_apply_req", qreq, 2'b11);
        rstn = 1'b0; #1;
        chk("rst_apply_req", qreq, 0);
        chk("rst_apply_gen", gen, 0);
        chk("rst_apply_act", act, RV);
        @(negedge clk); #1 rstn = 1'b1;

        ack_dly = 1;
        g0 = gen;
        repeat (256) wr(8'h02, 32'h1);
        wait_idle();
        chk("gen_wrap", gen, g0);

        repeat (200) begin
            ack_dly = $urandom_range(0, 6);
            stuck = ($urandom_range(0, 7) == 0) ? NT'($urandom_range(1, 3)) : '0;
            xact($urandom_range(0, 1) == 1, atab[$urandom_range(0, 11)],
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                 $urandom_range(0, 1) == 1, atab[$urandom_range(0, 11)]);
        end
        stuck = '0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
